// File: rtl/mips_pkg.sv
// Shared MIPS constants: ALU control codes, opcodes and R-type funct values.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd10,
        ALU_SRL = 4'd11,
        ALU_NOR = 4'd12,
        ALU_NOP = 4'd15
    } alu_ctrl_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/mips_fwd_mux.sv
// Three-way operand forwarding select: EX/MEM, then MEM/WB, then the fallback value.
module mips_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_we,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);
    import mips_pkg::*;

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_we && (mem_rd == idx) && (idx != '0);
    assign wb_hit  = wb_we  && (wb_rd  == idx) && (idx != '0);

    always_comb begin
        data = reg_data;
        if (mem_hit)
            data = mem_data;
        else if (wb_hit)
            data = wb_data;
    end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register: decodes to ALU control, selects/forwards operands and
// holds one instruction behind a valid/ready handshake feeding mips_alu directly.
module mips_id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rs_idx,
    input  logic [REG_AW-1:0] rt_idx,
    input  logic [REG_AW-1:0] rd_idx,
    input  logic [4:0]        shamt_in,
    input  logic [15:0]       imm16,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              fwd_mem_we,
    input  logic [REG_AW-1:0] fwd_mem_rd,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic              fwd_wb_we,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_shamt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_we,
    output logic              illegal
);
    import mips_pkg::*;

    logic [REG_AW-1:0] rs_q;
    logic [REG_AW-1:0] rt_q;
    logic              b_is_reg_q;

    logic              accept;
    logic              hold;

    alu_ctrl_e         dec_ctrl;
    logic              dec_legal;
    logic              dec_b_reg;
    logic              dec_sext;
    logic              dec_shift;
    logic [REG_AW-1:0] dec_dest;
    logic [DATA_W-1:0] imm_ext;

    logic [REG_AW-1:0] a_idx;
    logic [REG_AW-1:0] b_idx;
    logic [DATA_W-1:0] a_base;
    logic [DATA_W-1:0] b_base;
    logic [DATA_W-1:0] a_fwd;
    logic [DATA_W-1:0] b_fwd;

    assign in_ready = !ex_valid || ex_ready;
    assign accept   = in_valid && in_ready;
    assign hold     = ex_valid && !ex_ready;

    always_comb begin
        dec_ctrl  = ALU_NOP;
        dec_legal = 1'b0;
        dec_b_reg = 1'b1;
        dec_sext  = 1'b0;
        dec_shift = 1'b0;
        if (opcode == OP_RTYPE) begin
            dec_legal = 1'b1;
            case (funct)
                FN_AND:           dec_ctrl = ALU_AND;
                FN_OR:            dec_ctrl = ALU_OR;
                FN_ADD, FN_ADDU:  dec_ctrl = ALU_ADD;
                FN_SUB, FN_SUBU:  dec_ctrl = ALU_SUB;
                FN_SLT:           dec_ctrl = ALU_SLT;
                FN_NOR:           dec_ctrl = ALU_NOR;
                FN_SLL: begin
                    dec_ctrl  = ALU_SLL;
                    dec_shift = 1'b1;
                end
                FN_SRL: begin
                    dec_ctrl  = ALU_SRL;
                    dec_shift = 1'b1;
                end
                default:          dec_legal = 1'b0;
            endcase
        end else begin
            dec_legal = 1'b1;
            dec_b_reg = 1'b0;
            case (opcode)
                OP_ADDI: begin
                    dec_ctrl = ALU_ADD;
                    dec_sext = 1'b1;
                end
                OP_SLTI: begin
                    dec_ctrl = ALU_SLT;
                    dec_sext = 1'b1;
                end
                OP_ANDI:  dec_ctrl = ALU_AND;
                OP_ORI:   dec_ctrl = ALU_OR;
                default: begin
                    dec_legal = 1'b0;
                    dec_b_reg = 1'b1;
                end
            endcase
        end
    end

    assign dec_dest = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign imm_ext  = dec_sext ? {{(DATA_W-16){imm16[15]}}, imm16}
                               : {{(DATA_W-16){1'b0}}, imm16};

    // While holding, the same muxes re-forward the held operands against the stored indices.
    assign a_idx  = hold ? rs_q  : rs_idx;
    assign b_idx  = hold ? rt_q  : rt_idx;
    assign a_base = hold ? alu_a : rs_data;
    assign b_base = hold ? alu_b : rt_data;

    mips_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .idx      (a_idx),
        .reg_data (a_base),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .data     (a_fwd)
    );

    mips_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .idx      (b_idx),
        .reg_data (b_base),
        .mem_we   (fwd_mem_we),
        .mem_rd   (fwd_mem_rd),
        .mem_data (fwd_mem_data),
        .wb_we    (fwd_wb_we),
        .wb_rd    (fwd_wb_rd),
        .wb_data  (fwd_wb_data),
        .data     (b_fwd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            alu_ctrl   <= ALU_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_shamt  <= '0;
            ex_rd      <= '0;
            ex_we      <= 1'b0;
            illegal    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            b_is_reg_q <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            alu_ctrl   <= dec_ctrl;
            alu_a      <= a_fwd;
            alu_b      <= dec_b_reg ? b_fwd : imm_ext;
            alu_shamt  <= dec_shift ? shamt_in : 5'd0;
            ex_rd      <= dec_dest;
            ex_we      <= dec_legal && (dec_dest != '0);
            rs_q       <= rs_idx;
            rt_q       <= rt_idx;
            b_is_reg_q <= dec_b_reg;
            if (!dec_legal)
                illegal <= 1'b1;
        end else if (ex_valid && ex_ready) begin
            ex_valid <= 1'b0;
        end else if (hold) begin
            alu_a <= a_fwd;
            if (b_is_reg_q)
                alu_b <= b_fwd;
        end
    end

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Directed bench for mips_id_ex_stage with hand-computed expectations.
module tb_mips_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [4:0]  shamt_in;
    logic [15:0] imm16;
    logic [31:0] rs_data, rt_data;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_rd;
    logic [31:0] fwd_mem_data;
    logic        fwd_wb_we;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    mips_id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs_idx(rs_idx), .rt_idx(rt_idx),
        .rd_idx(rd_idx), .shamt_in(shamt_in), .imm16(imm16),
        .rs_data(rs_data), .rt_data(rt_data),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .ex_rd(ex_rd), .ex_we(ex_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_r(input logic [5:0] fn, input logic [4:0] rs, input logic [31:0] rsd,
                           input logic [4:0] rt, input logic [31:0] rtd,
                           input logic [4:0] rd, input logic [4:0] sh);
        in_valid = 1'b1; opcode = 6'h00; funct = fn;
        rs_idx = rs; rs_data = rsd; rt_idx = rt; rt_data = rtd;
        rd_idx = rd; shamt_in = sh; imm16 = 16'h0;
    endtask

    task automatic drive_i(input logic [5:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                           input logic [4:0] rt, input logic [15:0] imm);
        in_valid = 1'b1; opcode = op; funct = 6'h3F;
        rs_idx = rs; rs_data = rsd; rt_idx = rt; rt_data = 32'hDEAD_BEEF;
        rd_idx = 5'd31; shamt_in = 5'd9; imm16 = imm;
    endtask

    task automatic fwd_off();
        fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h0;
        fwd_wb_we  = 1'b0; fwd_wb_rd  = 5'd0; fwd_wb_data  = 32'h0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd0);
        check({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, 32'd15);
        check({tag, ".alu_a"}, alu_a, 32'd0);
        check({tag, ".alu_b"}, alu_b, 32'd0);
        check({tag, ".shamt"}, {27'd0, alu_shamt}, 32'd0);
        check({tag, ".ex_rd"}, {27'd0, ex_rd}, 32'd0);
        check({tag, ".ex_we"}, {31'd0, ex_we}, 32'd0);
        check({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        drive_r(6'h20, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        in_valid = 1'b0;
        fwd_off();
        step(); step();
        rst = 1'b0;
        check_reset("reset");
        check("reset.in_ready", {31'd0, in_ready}, 32'd1);

        // add r3 = r1 + r2
        drive_r(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'd4);
        step();
        check("add.valid", {31'd0, ex_valid}, 32'd1);
        check("add.ctrl", {28'd0, alu_ctrl}, 32'd2);
        check("add.a", alu_a, 32'd5);
        check("add.b", alu_b, 32'd7);
        check("add.rd", {27'd0, ex_rd}, 32'd3);
        check("add.we", {31'd0, ex_we}, 32'd1);
        check("add.shamt", {27'd0, alu_shamt}, 32'd0);

        drive_i(6'h08, 5'd1, 32'd5, 5'd4, 16'hFFFE);
        step();
        check("addi.b", alu_b, 32'hFFFF_FFFE);
        check("addi.ctrl", {28'd0, alu_ctrl}, 32'd2);
        check("addi.rd", {27'd0, ex_rd}, 32'd4);
        check("addi.shamt", {27'd0, alu_shamt}, 32'd0);

        drive_i(6'h0D, 5'd1, 32'd5, 5'd4, 16'hFFFE);
        step();
        check("ori.b", alu_b, 32'h0000_FFFE);
        check("ori.ctrl", {28'd0, alu_ctrl}, 32'd1);

        drive_i(6'h0A, 5'd1, 32'd5, 5'd6, 16'h8000);
        step();
        check("slti.b", alu_b, 32'hFFFF_8000);
        check("slti.ctrl", {28'd0, alu_ctrl}, 32'd7);

        // sub with both forwarding ports matching: EX/MEM wins
        drive_r(6'h22, 5'd5, 32'h99, 5'd2, 32'd7, 5'd8, 5'd0);
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h11;
        fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd5; fwd_wb_data  = 32'h22;
        step();
        check("sub.fwd_a", alu_a, 32'h11);
        check("sub.ctrl", {28'd0, alu_ctrl}, 32'd6);
        check("sub.b", alu_b, 32'd7);

        drive_r(6'h23, 5'd0, 32'h55, 5'd2, 32'd7, 5'd8, 5'd0);
        fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
        step();
        check("sub.r0_a", alu_a, 32'h55);
        check("subu.ctrl", {28'd0, alu_ctrl}, 32'd6);

        // MEM/WB-only forward onto rt
        drive_r(6'h27, 5'd1, 32'd5, 5'd9, 32'h1, 5'd10, 5'd0);
        fwd_mem_we = 1'b0; fwd_mem_rd = 5'd9;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd9; fwd_wb_data = 32'h33;
        step();
        check("nor.wb_b", alu_b, 32'h33);
        check("nor.ctrl", {28'd0, alu_ctrl}, 32'd12);
        fwd_off();

        // immediate operand is never forwarded even if rt matches
        drive_i(6'h0C, 5'd1, 32'd5, 5'd9, 16'h00F0);
        fwd_mem_we = 1'b1; fwd_mem_rd = 5'd9; fwd_mem_data = 32'h77;
        step();
        check("andi.imm_b", alu_b, 32'h0000_00F0);
        check("andi.ctrl", {28'd0, alu_ctrl}, 32'd0);
        fwd_off();

        drive_r(6'h00, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'd7);
        step();
        check("sll.ctrl", {28'd0, alu_ctrl}, 32'd10);
        check("sll.shamt", {27'd0, alu_shamt}, 32'd7);

        drive_r(6'h02, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'd31);
        step();
        check("srl.ctrl", {28'd0, alu_ctrl}, 32'd11);
        check("srl.shamt", {27'd0, alu_shamt}, 32'd31);

        drive_r(6'h2A, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 5'd3);
        step();
        check("slt.ctrl", {28'd0, alu_ctrl}, 32'd7);
        check("slt.rd0_we", {31'd0, ex_we}, 32'd0);
        check("slt.shamt", {27'd0, alu_shamt}, 32'd0);

        // drain: ex_valid drops, data holds
        in_valid = 1'b0;
        step();
        check("drain.valid", {31'd0, ex_valid}, 32'd0);
        check("drain.a_hold", alu_a, 32'd5);
        check("drain.b_hold", alu_b, 32'd7);

        // hold with MEM/WB refresh of rt
        drive_r(6'h24, 5'd1, 32'd5, 5'd6, 32'h10, 5'd7, 5'd0);
        step();
        check("hold.load_b", alu_b, 32'h10);
        ex_ready = 1'b0;
        drive_r(6'h25, 5'd1, 32'd5, 5'd2, 32'd7, 5'd9, 5'd0);
        #1;
        check("hold.in_ready0", {31'd0, in_ready}, 32'd0);
        step();
        check("hold.c1_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("hold.c1_b", alu_b, 32'h10);
        check("hold.c1_in_ready", {31'd0, in_ready}, 32'd0);
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd6; fwd_wb_data = 32'hAB;
        step();
        fwd_off();
        check("hold.c2_b", alu_b, 32'hAB);
        check("hold.c2_a", alu_a, 32'd5);
        check("hold.c2_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("hold.c3_b", alu_b, 32'hAB);
        check("hold.c3_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("hold.c3_rd", {27'd0, ex_rd}, 32'd7);
        ex_ready = 1'b1;
        #1;
        check("hold.in_ready1", {31'd0, in_ready}, 32'd1);
        step();
        check("hold.next_ctrl", {28'd0, alu_ctrl}, 32'd1);
        check("hold.next_rd", {27'd0, ex_rd}, 32'd9);
        check("hold.next_b", alu_b, 32'd7);

        // illegal opcode flows as a bubble, sticky flag survives flush
        drive_i(6'h3F, 5'd1, 32'd5, 5'd4, 16'h1234);
        step();
        check("ill.valid", {31'd0, ex_valid}, 32'd1);
        check("ill.ctrl", {28'd0, alu_ctrl}, 32'd15);
        check("ill.we", {31'd0, ex_we}, 32'd0);
        check("ill.flag", {31'd0, illegal}, 32'd1);
        drive_r(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", {31'd0, ex_valid}, 32'd0);
        check("flush.illegal", {31'd0, illegal}, 32'd1);
        step();
        check("flush.stays0", {31'd0, ex_valid}, 32'd0);

        // rst in the middle of a stall
        drive_r(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 5'd0);
        step();
        ex_ready = 1'b0;
        drive_r(6'h21, 5'd1, 32'd9, 5'd2, 32'd9, 5'd4, 5'd0);
        step();
        check("midhold.valid", {31'd0, ex_valid}, 32'd1);
        rst = 1'b1;
        step();
        check_reset("rst_hold");
        rst = 1'b0;
        in_valid = 1'b0;
        ex_ready = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
